// File: rtl/attopu_pkg.sv
// Shared widths and types for the attopu core.
package attopu_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, word} entries; flush beats push, head is read straight
// from registered storage so nothing combinational reaches the decoder.
module fetch_queue
  import attopu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (!flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the memory address and feeds the
// decoder through the prefetch queue; redirects flush and restart fetch.
module fetch_unit
  import attopu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              q_full, q_empty;
  logic              push, pop;
  fetch_entry_t      push_entry, head;

  assign mem_addr    = pc_q;
  assign instr_valid = !q_empty;
  assign instr       = head.word;
  assign instr_pc    = head.pc;

  assign pop  = !q_empty && instr_ready;
  assign push = fetch_en && !redirect && (!q_full || pop);

  assign push_entry.pc   = pc_q;
  assign push_entry.word = mem_data;

  // Redirect wins over sequential advance; PC wraps naturally at 16 bits.
  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = redirect_pc;
    else if (push) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

endmodule
